// File: rtl/arb_requester.sv
// arb_requester: queues burst commands and holds req to the arbiter until every beat is granted.
// Beats are counted only on granted cycles; a wait counter flags starvation.
module arb_requester #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int WAIT_W  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    input  logic [LEN_W-1:0]         i_cmd_len,
    output logic                     o_cmd_ready,
    output logic                     o_req,
    input  logic                     i_gnt,
    output logic                     o_beat_valid,
    output logic                     o_beat_last,
    output logic                     o_busy,
    output logic                     o_starved,
    output logic [WAIT_W-1:0]        o_wait_cnt,
    output logic [$clog2(DEPTH):0]   o_fifo_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [WAIT_W-1:0] TO = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WMAX = '1;
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
    state_t r_state, w_next;
    logic [LEN_W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0] r_cnt;
    logic [LEN_W-1:0] r_rem;
    logic [WAIT_W-1:0] r_wait;
    logic w_push, w_pop;
    assign o_cmd_ready  = r_cnt != FULL;
    assign w_push       = i_cmd_valid & o_cmd_ready;
    assign o_req        = r_state == ACTIVE;
    assign o_beat_valid = o_req & i_gnt;
    assign o_beat_last  = o_beat_valid & (r_rem == '0);
    assign o_busy       = (r_state != IDLE) | (r_cnt != '0);
    assign o_starved    = r_wait >= TO;
    assign o_wait_cnt   = r_wait;
    assign o_fifo_cnt   = r_cnt;
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE, GAP: begin
                w_pop  = r_cnt != '0;
                w_next = w_pop ? ACTIVE : IDLE;
            end
            ACTIVE:  w_next = o_beat_last ? GAP : ACTIVE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (w_push) begin
                r_mem[r_wptr] <= i_cmd_len;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push != w_pop) r_cnt <= w_push ? r_cnt + 1'b1 : r_cnt - 1'b1;
            // remaining stops at 0: the last beat moves the FSM to GAP instead
            r_rem  <= w_pop ? r_mem[r_rptr] : (o_beat_valid && r_rem != '0) ? r_rem - 1'b1 : r_rem;
            r_wait <= (o_req && !i_gnt) ? ((r_wait == WMAX) ? r_wait : r_wait + 1'b1) : '0;
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: randomized stimulus checked every cycle against a beat-counting reference model.
module tb_arb_requester;
    localparam int DEPTH = 4, LEN_W = 4, WAIT_W = 6, TIMEOUT = 16;
    localparam int WMAX = (1 << WAIT_W) - 1;
    logic clk = 0, rst = 0, cmd_valid = 0, gnt = 0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic cmd_ready, req, beat_valid, beat_last, busy, starved;
    logic [WAIT_W-1:0] wait_cnt;
    logic [$clog2(DEPTH):0] fifo_cnt;
    int n_checks = 0, n_errors = 0;
    int q[$];
    int cur = 0, waitc = 0;
    bit gap = 0;
    always #5 clk = ~clk;
    arb_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd_len(cmd_len),
        .o_cmd_ready(cmd_ready), .o_req(req), .i_gnt(gnt), .o_beat_valid(beat_valid),
        .o_beat_last(beat_last), .o_busy(busy), .o_starved(starved),
        .o_wait_cnt(wait_cnt), .o_fifo_cnt(fifo_cnt)
    );
    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        cur = 0;
        waitc = 0;
        gap = 0;
    endtask
    // cur = beats still owed for the active burst (0 = no burst); gap = the cycle after a last beat
    task automatic step(input int pv, input int pg, input int pr);
        bit push, g, r;
        int len;
        @(negedge clk);
        rst = $urandom_range(99) >= pr;
        cmd_valid = $urandom_range(99) < pv;
        gnt = $urandom_range(99) < pg;
        cmd_len = LEN_W'($urandom_range(15));
        #1;
        check("req", int'(req), int'(cur > 0));
        check("cmd_ready", int'(cmd_ready), int'(q.size() < DEPTH));
        check("beat_valid", int'(beat_valid), int'(cur > 0 && gnt));
        check("beat_last", int'(beat_last), int'(cur == 1 && gnt));
        check("busy", int'(busy), int'(cur > 0 || gap || q.size() != 0));
        check("fifo_cnt", int'(fifo_cnt), q.size());
        check("wait_cnt", int'(wait_cnt), waitc);
        check("starved", int'(starved), int'(waitc >= TIMEOUT));
        push = cmd_valid && q.size() < DEPTH;
        g = gnt;
        r = rst;
        len = int'(cmd_len);
        @(posedge clk);
        if (!r) model_reset();
        else begin
            if (cur > 0) begin
                if (g) begin
                    cur--;
                    waitc = 0;
                    gap = cur == 0;
                end else waitc = (waitc < WMAX) ? waitc + 1 : WMAX;
            end else begin
                waitc = 0;
                gap = 0;
                if (q.size() != 0) cur = q.pop_front() + 1;
            end
            if (push) q.push_back(len);
        end
    endtask
    task automatic run(input int n, input int pv, input int pg, input int pr);
        for (int i = 0; i < n; i++) step(pv, pg, pr);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        model_reset();
        run(1, 100, 100, 0);
        run(40, 0, 100, 0);
        run(12, 100, 0, 0);
        run(100, 0, 0, 0);
        run(80, 0, 100, 0);
        run(30, 100, 0, 0);
        run(3, 0, 100, 0);
        run(60, 0, 0, 0);
        run(400, 40, 60, 0);
        run(600, 50, 70, 2);
        run(300, 60, 15, 1);
        run(200, 0, 100, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
